// File: rtl/i2c_gpio_expander_target_pkg.sv
// Shared definitions for the I2C GPIO expander target:
// FSM states, register pair indices, reset values, pointer helper.
package i2c_gpio_expander_target_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_RD_LOAD,
        ST_IGNORE
    } state_t;

    // ptr[2:1] selects the register pair, ptr[0] the byte lane
    localparam logic [1:0] PAIR_IN  = 2'd0;
    localparam logic [1:0] PAIR_OUT = 2'd1;
    localparam logic [1:0] PAIR_POL = 2'd2;
    localparam logic [1:0] PAIR_CFG = 2'd3;

    localparam logic [15:0] OUT_RST = 16'hFFFF;
    localparam logic [15:0] POL_RST = 16'h0000;
    localparam logic [15:0] CFG_RST = 16'hFFFF;

    function automatic logic [2:0] pair_toggle(input logic [2:0] p);
        return {p[2:1], ~p[0]};
    endfunction

endpackage

// File: rtl/i2c_target_bit_phy.sv
// I2C target bit layer: SCL/SDA synchronisers, edge and START/STOP
// detection, open-drain SDA driver.
// Ports: clk, rst (async, high); scl in; sda inout (0 or z);
//   drive_low in (pull SDA low); scl_rise/scl_fall/start/stop pulses;
//   sda_bit = synchronised SDA level.
module i2c_target_bit_phy
    import i2c_gpio_expander_target_pkg::*;
#(
    parameter int SYNC_LEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    inout  wire  sda,
    input  logic drive_low,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_bit
);

    logic [SYNC_LEN-1:0] scl_sync;
    logic [SYNC_LEN-1:0] sda_sync;
    logic                scl_prev;
    logic                sda_prev;
    logic                scl_s;
    logic                sda_s;

    assign scl_s = scl_sync[SYNC_LEN-1];
    assign sda_s = sda_sync[SYNC_LEN-1];

    // Idle bus is high on both lines, so reset the pipes high to
    // avoid a phantom edge or START when reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_LEN-2:0], scl};
            sda_sync <= {sda_sync[SYNC_LEN-2:0], sda};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_rise = scl_s & ~scl_prev;
    assign scl_fall = ~scl_s & scl_prev;
    assign start    = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop     = scl_s & scl_prev & ~sda_prev & sda_s;
    assign sda_bit  = sda_s;

    assign sda = drive_low ? 1'b0 : 1'bz;

endmodule

// File: rtl/i2c_gpio_expander_target.sv
// TCA9555-style 16-bit GPIO expander as an I2C target.
// Ports: i_clk, i_reset (async, high); io_scl in; io_sda open-drain;
//   i_port pin levels; o_port/o_port_oe pin drive; o_int change irq;
//   o_busy high from address-matched START until STOP.
module i2c_gpio_expander_target
    import i2c_gpio_expander_target_pkg::*;
#(
    parameter logic [6:0] SADR     = 7'b0100_000,
    parameter int         SYNC_LEN = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        io_scl,
    inout  wire         io_sda,
    input  logic [15:0] i_port,
    output logic [15:0] o_port,
    output logic [15:0] o_port_oe,
    output logic        o_int,
    output logic        o_busy
);

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda_bit;
    logic drive_low;

    i2c_target_bit_phy #(
        .SYNC_LEN (SYNC_LEN)
    ) u_phy (
        .clk       (i_clk),
        .rst       (i_reset),
        .scl       (io_scl),
        .sda       (io_sda),
        .drive_low (drive_low),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start     (start),
        .stop      (stop),
        .sda_bit   (sda_bit)
    );

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  ptr;
    logic [6:0]  shreg;
    logic [6:0]  txsh;
    logic        rw;
    logic        ack_on;
    logic [15:0] out_q;
    logic [15:0] pol_q;
    logic [15:0] cfg_q;
    logic [15:0] snap;
    logic [15:0] port_s;
    logic [7:0]  rx_byte;
    logic [7:0]  rd_byte;
    logic [3:0]  lane;

    logic [16*SYNC_LEN-1:0] port_pipe;

    assign port_s  = port_pipe[16*SYNC_LEN-1 -: 16];
    assign rx_byte = {shreg, sda_bit};
    assign lane    = {ptr[0], 3'b000};

    assign o_port    = out_q;
    assign o_port_oe = ~cfg_q;

    always_comb begin
        rd_byte = 8'h00;
        unique case (ptr[2:1])
            PAIR_IN:  rd_byte = snap[lane +: 8] ^ pol_q[lane +: 8];
            PAIR_OUT: rd_byte = out_q[lane +: 8];
            PAIR_POL: rd_byte = pol_q[lane +: 8];
            PAIR_CFG: rd_byte = cfg_q[lane +: 8];
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            port_pipe <= '0;
            o_int     <= 1'b0;
        end else begin
            port_pipe <= {port_pipe[16*SYNC_LEN-17:0], i_port};
            // Only pins configured as inputs can raise the interrupt;
            // it drops by itself once pins match the snapshot again.
            o_int     <= |((port_s ^ snap) & cfg_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            ptr       <= 3'd0;
            shreg     <= 7'd0;
            txsh      <= 7'd0;
            rw        <= 1'b0;
            ack_on    <= 1'b0;
            drive_low <= 1'b0;
            o_busy    <= 1'b0;
            out_q     <= OUT_RST;
            pol_q     <= POL_RST;
            cfg_q     <= CFG_RST;
            snap      <= 16'h0000;
        end else if (stop) begin
            state     <= ST_IDLE;
            drive_low <= 1'b0;
            o_busy    <= 1'b0;
        end else if (start) begin
            // Registers only change on a completed byte, so a START
            // mid-byte simply drops the partial shift.
            state     <= ST_ADDR;
            cnt       <= 3'd0;
            drive_low <= 1'b0;
        end else begin
            unique case (state)
                ST_ADDR: if (scl_rise) begin
                    shreg <= rx_byte[6:0];
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (shreg == SADR) begin
                            state  <= ST_ADDR_ACK;
                            ack_on <= 1'b0;
                            rw     <= sda_bit;
                            o_busy <= 1'b1;
                            if (sda_bit && ptr[2:1] == PAIR_IN)
                                snap <= port_s;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                end
                // First fall after the 8th bit starts the ACK, the
                // next fall ends it (and may start read data).
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: if (scl_fall) begin
                    if (!ack_on) begin
                        ack_on    <= 1'b1;
                        drive_low <= 1'b1;
                    end else begin
                        ack_on <= 1'b0;
                        cnt    <= 3'd0;
                        if (state == ST_ADDR_ACK && rw) begin
                            txsh      <= rd_byte[6:0];
                            drive_low <= ~rd_byte[7];
                            state     <= ST_RD_BYTE;
                        end else begin
                            drive_low <= 1'b0;
                            state     <= (state == ST_ADDR_ACK) ?
                                         ST_PTR : ST_WR_BYTE;
                        end
                    end
                end
                ST_PTR: if (scl_rise) begin
                    shreg <= rx_byte[6:0];
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        ptr    <= rx_byte[2:0];
                        state  <= ST_PTR_ACK;
                        ack_on <= 1'b0;
                    end
                end
                ST_WR_BYTE: if (scl_rise) begin
                    shreg <= rx_byte[6:0];
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        unique case (ptr[2:1])
                            PAIR_IN:  ;
                            PAIR_OUT: out_q[lane +: 8] <= rx_byte;
                            PAIR_POL: pol_q[lane +: 8] <= rx_byte;
                            PAIR_CFG: cfg_q[lane +: 8] <= rx_byte;
                        endcase
                        ptr    <= pair_toggle(ptr);
                        state  <= ST_WR_ACK;
                        ack_on <= 1'b0;
                    end
                end
                ST_RD_BYTE: if (scl_rise) begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7)
                        state <= ST_RD_ACK;
                end else if (scl_fall) begin
                    drive_low <= ~txsh[6];
                    txsh      <= {txsh[5:0], 1'b0};
                end
                ST_RD_ACK: if (scl_fall) begin
                    drive_low <= 1'b0;
                end else if (scl_rise) begin
                    if (sda_bit) begin
                        state <= ST_IGNORE;
                    end else begin
                        ptr   <= pair_toggle(ptr);
                        state <= ST_RD_LOAD;
                    end
                end
                ST_RD_LOAD: if (scl_fall) begin
                    txsh      <= rd_byte[6:0];
                    drive_low <= ~rd_byte[7];
                    cnt       <= 3'd0;
                    state     <= ST_RD_BYTE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_gpio_expander_target.sv
// Directed bench for i2c_gpio_expander_target: bit-banged I2C host,
// expected values queued at stimulus time and compared on output.
module tb_i2c_gpio_expander_target;

    localparam int T = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        host_low = 1'b0;
    logic [15:0] port_in = 16'h0000;
    logic [15:0] port;
    logic [15:0] port_oe;
    logic        irq;
    logic        busy;
    wire         sda;

    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] sb[$];

    pullup (sda);
    assign sda = host_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_gpio_expander_target dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .io_scl    (scl),
        .io_sda    (sda),
        .i_port    (port_in),
        .o_port    (port),
        .o_port_oe (port_oe),
        .o_int     (irq),
        .o_busy    (busy)
    );

    function automatic logic [15:0] b16(input logic b);
        return {15'd0, b};
    endfunction

    task automatic push(input logic [15:0] v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        n_chk++;
        if (sb.size() == 0) begin
            $error("FAIL %s: observed %h, nothing expected", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) n_pass++;
            else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sig(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        push(exp);
        chk(tag, obs);
    endtask

    task automatic bit_io(input logic b, output logic r);
        #T host_low = ~b;
        #T scl = 1'b1;
        #T r = sda;
        #T scl = 1'b0;
    endtask

    task automatic i2c_start();
        host_low = 1'b0;
        #T scl = 1'b1;
        #T host_low = 1'b1;
        #T scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #T host_low = 1'b1;
        #T scl = 1'b1;
        #T host_low = 1'b0;
        #T;
    endtask

    task automatic wr(input string tag, input logic [7:0] d,
                      input logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(d[i], r);
        push(b16(acked));
        bit_io(1'b1, r);
        chk(tag, b16(~r));
    endtask

    task automatic rd(input string tag, input logic [7:0] exp,
                      input logic ack);
        logic r;
        logic [7:0] d;
        push({8'd0, exp});
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            d[i] = r;
        end
        bit_io(~ack, r);
        chk(tag, {8'd0, d});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        logic r;
        logic [7:0] d;

        #30 rst = 1'b0;
        #20;
        sig("rst_port", port, 16'hFFFF);
        sig("rst_oe", port_oe, 16'h0000);
        sig("rst_int", b16(irq), 16'd0);
        sig("rst_busy", b16(busy), 16'd0);
        sig("rst_sda", b16(sda), 16'd1);

        // 1: config both pairs as outputs
        i2c_start();
        wr("t1_addr", 8'h40, 1'b1);
        sig("t1_busy", b16(busy), 16'd1);
        wr("t1_ptr", 8'h06, 1'b1);
        wr("t1_d0", 8'h00, 1'b1);
        wr("t1_d1", 8'h00, 1'b1);
        i2c_stop();
        sig("t1_oe", port_oe, 16'hFFFF);
        sig("t1_busy_off", b16(busy), 16'd0);

        // 2: output regs with pair toggle
        i2c_start();
        wr("t2_addr", 8'h40, 1'b1);
        wr("t2_ptr", 8'h02, 1'b1);
        wr("t2_d0", 8'hA5, 1'b1);
        wr("t2_d1", 8'h3C, 1'b1);
        i2c_stop();
        sig("t2_port", port, 16'h3CA5);

        // 3: inputs, polarity, read with repeated START
        port_in = 16'h1234;
        #(T * 2);
        sig("t3_int_masked", b16(irq), 16'd0);
        i2c_start();
        wr("t3_addr", 8'h40, 1'b1);
        wr("t3_ptr", 8'h06, 1'b1);
        wr("t3_c0", 8'hFF, 1'b1);
        wr("t3_c1", 8'hFF, 1'b1);
        i2c_stop();
        #(T * 2);
        sig("t3_oe", port_oe, 16'h0000);
        sig("t3_int_set", b16(irq), 16'd1);
        i2c_start();
        wr("t3_paddr", 8'h40, 1'b1);
        wr("t3_pptr", 8'hFC, 1'b1);
        wr("t3_pol", 8'h0F, 1'b1);
        i2c_stop();
        i2c_start();
        wr("t3_waddr", 8'h40, 1'b1);
        wr("t3_rptr", 8'h00, 1'b1);
        i2c_start();
        wr("t3_raddr", 8'h41, 1'b1);
        rd("t3_in0", 8'h3B, 1'b1);
        rd("t3_in1", 8'h12, 1'b0);
        #T;
        sig("t3_nack_sda", b16(sda), 16'd1);
        i2c_stop();
        sig("t3_int_clr", b16(irq), 16'd0);

        // 4: input change interrupt
        port_in = 16'h123C;
        #(T * 2);
        sig("t4_int_set", b16(irq), 16'd1);
        i2c_start();
        wr("t4_waddr", 8'h40, 1'b1);
        wr("t4_ptr", 8'h00, 1'b1);
        i2c_start();
        wr("t4_raddr", 8'h41, 1'b1);
        rd("t4_in0", 8'h33, 1'b0);
        i2c_stop();
        sig("t4_int_clr", b16(irq), 16'd0);
        port_in = 16'h123D;
        #(T * 2);
        sig("t4_int_pin", b16(irq), 16'd1);
        port_in = 16'h123C;
        #(T * 2);
        sig("t4_int_back", b16(irq), 16'd0);

        // 5: foreign address is ignored
        i2c_start();
        wr("t5_addr", 8'h42, 1'b0);
        sig("t5_busy", b16(busy), 16'd0);
        wr("t5_ptr", 8'h02, 1'b0);
        wr("t5_data", 8'h00, 1'b0);
        i2c_stop();
        sig("t5_port", port, 16'h3CA5);

        // 6: reset while the target drives ACK, then mid-byte
        i2c_start();
        wr("t6_addr", 8'h40, 1'b1);
        wr("t6_ptr", 8'h02, 1'b1);
        d = 8'h55;
        for (int i = 7; i >= 0; i--) bit_io(d[i], r);
        #T;
        sig("t6_ack_low", b16(sda), 16'd0);
        rst = 1'b1;
        #1;
        sig("t6_sda_rel", b16(sda), 16'd1);
        sig("t6_port_rst", port, 16'hFFFF);
        #(T - 1) rst = 1'b0;
        i2c_stop();
        i2c_start();
        wr("t6_addr2", 8'h40, 1'b1);
        wr("t6_ptr2", 8'h02, 1'b1);
        for (int i = 0; i < 4; i++) bit_io(1'b0, r);
        rst = 1'b1;
        #T;
        sig("t6_mid_port", port, 16'hFFFF);
        sig("t6_mid_busy", b16(busy), 16'd0);
        rst = 1'b0;
        i2c_stop();
        i2c_start();
        wr("t6_addr3", 8'h40, 1'b1);
        wr("t6_ptr3", 8'h02, 1'b1);
        wr("t6_d3", 8'h5A, 1'b1);
        i2c_stop();
        sig("t6_port_new", port, 16'hFF5A);
        sig("t6_oe_new", port_oe, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
